// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the MIPS load/store bus unit.
// Holds the load/store type encodings, the access FSM state and the
// byteenable constants used by mips_cpu_bus_mem_access.
package mips_cpu_bus_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4,
    LT_LWL = 3'd5,
    LT_LWR = 3'd6
  } load_type_t;

  typedef enum logic [1:0] {
    ST_SW = 2'd0,
    ST_SB = 2'd1,
    ST_SH = 2'd2
  } store_type_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mem_state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

endpackage

// File: rtl/mips_cpu_bus_load_align.sv
// Load data alignment / extension (purely combinational).
// Ports:
//   i_readdata     32  bus word as read (lane k = byte at word address + k)
//   i_rt_old       32  current rt value, merged by LWL/LWR
//   i_load_type     3  load_type_t encoding
//   i_b             2  byte offset of the effective address
//   o_load_result  32  register-file write value
module mips_cpu_bus_load_align
  import mips_cpu_bus_pkg::*;
(
  input  logic [31:0] i_readdata,
  input  logic [31:0] i_rt_old,
  input  logic [2:0]  i_load_type,
  input  logic [1:0]  i_b,
  output logic [31:0] o_load_result
);

  logic [5:0]  w_rsh;     // 8*b
  logic [5:0]  w_lsh;     // 8*(3-b)
  logic [5:0]  w_keep_sh; // 8*(b+1): rt_old bits LWL keeps = 32 - that
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_rsh     = {1'b0, i_b, 3'b000};
    w_lsh     = {1'b0, ~i_b, 3'b000};
    w_keep_sh = 6'd32 - w_lsh;
    w_byte    = 8'(i_readdata >> w_rsh);
    w_half    = i_b[1] ? i_readdata[31:16] : i_readdata[15:0];
    case (load_type_t'(i_load_type))
      LT_LB:   o_load_result = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_load_result = {24'h0, w_byte};
      LT_LH:   o_load_result = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_load_result = {16'h0, w_half};
      // Shift amount 32 (b=3) yields an all-zero keep mask.
      LT_LWL:  o_load_result = (i_readdata << w_lsh) |
                               (i_rt_old & (32'hFFFF_FFFF >> w_keep_sh));
      LT_LWR:  o_load_result = (i_readdata >> w_rsh) |
                               (i_rt_old & ~(32'hFFFF_FFFF >> w_rsh));
      default: o_load_result = i_readdata;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_mem_access.sv
// Load/store unit: one Avalon-style read or write per request.
// Optional macro: MEM_ALIGN_CHECK_EN adds the misaligned output and
// suppresses the bus cycle for misaligned LW/SW/LH/LHU/SH.
// Ports:
//   clk, reset (async, active high)
//   start, load, store, load_type, store_type, eff_addr, store_data, rt_old
//                       request from the sequencer, sampled in IDLE only
//   busy, done, load_result   status / result (result held until next start)
//   address, read, write, writedata, byteenable, waitrequest, readdata
//                       Avalon data master
//   misaligned          (MEM_ALIGN_CHECK_EN only) valid with done
// DATA_W must be 32.
module mips_cpu_bus_mem_access
  import mips_cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load,
  input  logic              store,
  input  logic [2:0]        load_type,
  input  logic [1:0]        store_type,
  input  logic [ADDR_W-1:0] eff_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rt_old,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_result,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [3:0]        byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  mem_state_t        r_state, w_next;
  logic              r_is_load;
  logic [2:0]        r_load_type;
  logic [1:0]        r_b;
  logic [DATA_W-1:0] r_rt_old, r_load_result, r_writedata;
  logic [ADDR_W-1:0] r_address;
  logic [3:0]        r_byteenable;

  logic [1:0]        w_b;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_align;
  logic              w_misal, w_access;

  assign w_b = eff_addr[1:0];

  // Request decode, evaluated on the raw inputs while IDLE. Load wins over store.
  always_comb begin
    w_be    = BE_WORD;
    w_wdata = store_data;
    w_misal = 1'b0;
    if (load) begin
      case (load_type_t'(load_type))
        LT_LB, LT_LBU: w_be = 4'b0001 << w_b;
        LT_LH, LT_LHU: begin
          w_be = w_b[1] ? BE_HALF_HI : BE_HALF_LO;
`ifdef MEM_ALIGN_CHECK_EN
          w_misal = w_b[0];
`endif
        end
        LT_LWL, LT_LWR: w_be = BE_WORD;
        default: begin
          w_be = BE_WORD;
`ifdef MEM_ALIGN_CHECK_EN
          w_misal = (w_b != 2'b00);
`endif
        end
      endcase
    end else if (store) begin
      case (store_type_t'(store_type))
        ST_SB: begin
          w_be    = 4'b0001 << w_b;
          w_wdata = {4{store_data[7:0]}};
        end
        ST_SH: begin
          w_be    = w_b[1] ? BE_HALF_HI : BE_HALF_LO;
          w_wdata = {2{store_data[15:0]}};
`ifdef MEM_ALIGN_CHECK_EN
          w_misal = w_b[0];
`endif
        end
        default: begin
          w_be = BE_WORD;
`ifdef MEM_ALIGN_CHECK_EN
          w_misal = (w_b != 2'b00);
`endif
        end
      endcase
    end
    w_access = (load | store) & ~w_misal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Strobes come straight from state so an async reset drops them at once.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    read   = 1'b0;
    write  = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = w_access ? S_ACCESS : S_DONE;
      S_ACCESS: begin
        busy  = 1'b1;
        read  = r_is_load;
        write = ~r_is_load;
        if (!waitrequest) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_load     <= 1'b0;
      r_load_type   <= 3'd0;
      r_b           <= 2'd0;
      r_rt_old      <= '0;
      r_load_result <= '0;
      r_writedata   <= '0;
      r_address     <= '0;
      r_byteenable  <= 4'b0000;
    end else begin
      if (r_state == S_IDLE && start && w_access) begin
        r_is_load    <= load;
        r_load_type  <= load_type;
        r_b          <= w_b;
        r_rt_old     <= rt_old;
        r_writedata  <= w_wdata;
        r_address    <= {eff_addr[ADDR_W-1:2], 2'b00};
        r_byteenable <= w_be;
      end
      if (r_state == S_ACCESS && !waitrequest && r_is_load)
        r_load_result <= w_align;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misaligned;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          r_misaligned <= 1'b0;
    else if (r_state == S_IDLE && start) r_misaligned <= w_misal;
  end
  assign misaligned = r_misaligned;
`endif

  mips_cpu_bus_load_align u_align (
    .i_readdata    (readdata),
    .i_rt_old      (r_rt_old),
    .i_load_type   (r_load_type),
    .i_b           (r_b),
    .o_load_result (w_align)
  );

  assign load_result = r_load_result;
  assign address     = r_address;
  assign writedata   = r_writedata;
  assign byteenable  = r_byteenable;

endmodule

// File: tb/tb_mips_cpu_bus_mem_access.sv
// Bench for mips_cpu_bus_mem_access: byte-level model of each request builds a
// per-cycle expectation queue that one compare process checks; directed
// literal expectations pin the model.
module tb_mips_cpu_bus_mem_access;

  logic        clk = 1'b0;
  logic        reset, start, load, store, waitrequest;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] eff_addr, store_data, rt_old, readdata;
  logic        busy, done, read, write;
  logic [31:0] load_result, address, writedata;
  logic [3:0]  byteenable;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int checks = 0;
  int failures = 0;

  mips_cpu_bus_mem_access dut (
    .clk(clk), .reset(reset), .start(start), .load(load), .store(store),
    .load_type(load_type), .store_type(store_type), .eff_addr(eff_addr),
    .store_data(store_data), .rt_old(rt_old), .busy(busy), .done(done),
    .load_result(load_result), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata)
`ifdef MEM_ALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e_busy, e_done, e_rd, e_wr, e_mis;
    logic [31:0] e_addr, e_wdata, e_res;
    logic [3:0]  e_be;
  } exp_t;

  exp_t        q[$];
  bit          model_on = 0;
  logic [31:0] m_last_res = 0;
  int          cyc, done_at, strobe_cnt;
  logic [31:0] cap_addr, cap_wdata, cap_res;
  logic [3:0]  cap_be;
  logic        cap_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- model ----
  function automatic int m_size(input logic ld, input logic [2:0] lt, input logic [1:0] st);
    if (ld) begin
      if (lt == 3'd1 || lt == 3'd2) return 1;
      if (lt == 3'd3 || lt == 3'd4) return 2;
      return 4;
    end
    if (st == 2'd1) return 1;
    if (st == 2'd2) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input int sz, input logic [1:0] b);
    logic [3:0] be;
    int base;
    be = 4'b0000;
    base = (sz == 4) ? 0 : (sz == 2) ? (int'(b) / 2) * 2 : int'(b);
    for (int k = 0; k < sz; k++) be[base + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] sd);
    logic [31:0] wd;
    for (int k = 0; k < 4; k++) wd[8*k +: 8] = sd[8*(k % sz) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [31:0] rd,
                                         input logic [31:0] rt, input logic [1:0] b);
    logic [7:0]  rb[4];
    logic [7:0]  res[4];
    logic [15:0] h;
    int bi, hb;
    bi = int'(b);
    hb = int'(b[1]) * 2;
    for (int k = 0; k < 4; k++) begin
      rb[k]  = rd[8*k +: 8];
      res[k] = rt[8*k +: 8];
    end
    h = {rb[hb+1], rb[hb]};
    case (lt)
      3'd1: return {{24{rb[bi][7]}}, rb[bi]};
      3'd2: return {24'h0, rb[bi]};
      3'd3: return {{16{h[15]}}, h};
      3'd4: return {16'h0, h};
      3'd5: begin
        for (int i = 0; i <= bi; i++) res[3 - bi + i] = rb[i];
        return {res[3], res[2], res[1], res[0]};
      end
      3'd6: begin
        for (int i = 0; i < 4 - bi; i++) res[i] = rb[bi + i];
        return {res[3], res[2], res[1], res[0]};
      end
      default: return rd;
    endcase
  endfunction

  // ---- compare process ----
  initial begin : cmp
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (read | write) begin
        strobe_cnt++;
        cap_addr = address; cap_be = byteenable; cap_wdata = writedata;
      end
      if (done) begin
        done_at = cyc;
        cap_res = load_result;
`ifdef MEM_ALIGN_CHECK_EN
        cap_mis = misaligned;
`endif
      end
      if (model_on) begin
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("busy", busy, e.e_busy);
          chk("done", done, e.e_done);
          chk("read", read, e.e_rd);
          chk("write", write, e.e_wr);
          if (e.e_rd | e.e_wr) begin
            chk("address", address, e.e_addr);
            chk("byteenable", byteenable, e.e_be);
            if (e.e_wr) chk("writedata", writedata, e.e_wdata);
          end
          chk("load_result", load_result, e.e_res);
          if (e.e_done) begin
            m_last_res = e.e_res;
`ifdef MEM_ALIGN_CHECK_EN
            chk("misaligned", misaligned, e.e_mis);
`endif
          end
        end else begin
          chk("idle_busy", busy, 0);
          chk("idle_done", done, 0);
          chk("idle_strobe", read | write, 0);
          chk("held_result", load_result, m_last_res);
        end
      end
    end
  end

  // ---- request driver: fills the expectation queue, then plays the slave ----
  task automatic do_req(input logic ld, input logic st_v, input logic [2:0] lt,
                        input logic [1:0] st, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rt, input logic [31:0] rd, input int nwait,
                        input bit hold);
    exp_t e;
    int sz;
    logic [1:0] b;
    logic mis, acc;
    logic [31:0] res;
    b   = addr[1:0];
    sz  = m_size(ld, lt, st);
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if ((ld | st_v) && ((sz == 2 && b[0]) ||
        (sz == 4 && !(ld && (lt == 3'd5 || lt == 3'd6)) && b != 2'b00)))
      mis = 1'b1;
`endif
    acc = (ld | st_v) && !mis;
    res = (acc && ld) ? m_load(lt, rd, rt, b) : m_last_res;
    @(negedge clk);
    load = ld; store = st_v; load_type = lt; store_type = st;
    eff_addr = addr; store_data = sd; rt_old = rt; readdata = rd;
    waitrequest = (nwait > 0); start = 1'b1;
    cyc = 0; strobe_cnt = 0; done_at = -1;
    if (acc) begin
      for (int j = 0; j <= nwait; j++) begin
        e.e_busy = 1; e.e_done = 0; e.e_rd = ld; e.e_wr = !ld; e.e_mis = 0;
        e.e_addr = {addr[31:2], 2'b00}; e.e_be = m_be(sz, b);
        e.e_wdata = m_wdata(sz, sd); e.e_res = m_last_res;
        q.push_back(e);
      end
    end
    e.e_busy = 1; e.e_done = 1; e.e_rd = 0; e.e_wr = 0; e.e_mis = mis;
    e.e_addr = 0; e.e_be = 0; e.e_wdata = 0; e.e_res = res;
    q.push_back(e);
    for (int j = 0; j < nwait + 3; j++) begin
      @(negedge clk);
      waitrequest = (j < nwait);
      if (!hold || j >= nwait + 2) start = 1'b0;
      if (hold) begin eff_addr = ~addr; store_data = ~sd; load_type = 3'd1; end
    end
    if (q.size() != 0) begin
      chk("queue_drained", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin : main
    reset = 1; start = 0; load = 0; store = 0; load_type = 0; store_type = 0;
    eff_addr = 0; store_data = 0; rt_old = 0; readdata = 0; waitrequest = 0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_address", address, 0);
    chk("rst_writedata", writedata, 0);
    chk("rst_byteenable", byteenable, 0);
    chk("rst_load_result", load_result, 0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("rst_misaligned", misaligned, 0);
`endif
    @(negedge clk); @(negedge clk);
    reset = 0; model_on = 1;

    // SW
    do_req(0, 1, 3'd0, 2'd0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("lit_sw_be", cap_be, 4'b1111);
    chk("lit_sw_wdata", cap_wdata, 32'hDEADBEEF);
    chk("lit_sw_strobes", strobe_cnt, 1);
    chk("lit_sw_latency", done_at, 2);
    // SB
    do_req(0, 1, 3'd0, 2'd1, 32'h203, 32'h000000A5, 0, 0, 1, 0);
    chk("lit_sb_addr", cap_addr, 32'h200);
    chk("lit_sb_be", cap_be, 4'b1000);
    chk("lit_sb_wdata", cap_wdata, 32'hA5A5A5A5);
    // LB with 3 wait cycles, LBU
    do_req(1, 0, 3'd1, 2'd0, 32'h102, 0, 0, 32'h0080FF00, 3, 0);
    chk("lit_lb_strobes", strobe_cnt, 4);
    chk("lit_lb_latency", done_at, 5);
    chk("lit_lb_result", cap_res, 32'hFFFFFF80);
    do_req(1, 0, 3'd2, 2'd0, 32'h102, 0, 0, 32'h0080FF00, 0, 0);
    chk("lit_lbu_result", cap_res, 32'h00000080);
    // LWL / LWR
    do_req(1, 0, 3'd5, 2'd0, 32'h101, 0, 32'hAABBCCDD, 32'h44332211, 0, 0);
    chk("lit_lwl_result", cap_res, 32'h2211CCDD);
    do_req(1, 0, 3'd6, 2'd0, 32'h101, 0, 32'hAABBCCDD, 32'h44332211, 1, 0);
    chk("lit_lwr_result", cap_res, 32'hAA443322);
    do_req(1, 0, 3'd5, 2'd0, 32'h103, 0, 32'hAABBCCDD, 32'h44332211, 0, 0);
    do_req(1, 0, 3'd5, 2'd0, 32'h100, 0, 32'hAABBCCDD, 32'h44332211, 0, 0);
    do_req(1, 0, 3'd6, 2'd0, 32'h100, 0, 32'hAABBCCDD, 32'h44332211, 0, 0);
    do_req(1, 0, 3'd6, 2'd0, 32'h103, 0, 32'hAABBCCDD, 32'h44332211, 0, 0);
    chk("lit_lwr3_result", cap_res, 32'hAABBCC44);
    // Halfwords
    do_req(1, 0, 3'd3, 2'd0, 32'h102, 0, 0, 32'h80011234, 0, 0);
    chk("lit_lh_result", cap_res, 32'hFFFF8001);
    do_req(1, 0, 3'd4, 2'd0, 32'h100, 0, 0, 32'h80011234, 0, 0);
    chk("lit_lhu_result", cap_res, 32'h00001234);
    do_req(0, 1, 3'd0, 2'd2, 32'h102, 32'h1234BEEF, 0, 0, 0, 0);
    chk("lit_sh_be", cap_be, 4'b1100);
    chk("lit_sh_wdata", cap_wdata, 32'hBEEFBEEF);
    // LW with waits, start and inputs wiggling while busy
    do_req(1, 0, 3'd0, 2'd0, 32'h200, 0, 0, 32'h12345678, 2, 1);
    chk("lit_lw_hold_addr", cap_addr, 32'h200);
    chk("lit_lw_hold_result", cap_res, 32'h12345678);
    // No-op start: done with no bus cycle, result unchanged
    do_req(0, 0, 3'd0, 2'd0, 32'h300, 0, 0, 32'h55555555, 0, 0);
    chk("lit_noop_latency", done_at, 1);
    chk("lit_noop_strobes", strobe_cnt, 0);
    chk("lit_noop_result", cap_res, 32'h12345678);
    // load and store both high: load wins
    do_req(1, 1, 3'd0, 2'd0, 32'h300, 32'h11111111, 0, 32'h87654321, 0, 0);
    chk("lit_both_result", cap_res, 32'h87654321);
    // Misaligned word load
    do_req(1, 0, 3'd0, 2'd0, 32'h102, 0, 0, 32'hCAFEF00D, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("lit_mis_latency", done_at, 1);
    chk("lit_mis_strobes", strobe_cnt, 0);
    chk("lit_mis_flag", cap_mis, 1);
    chk("lit_mis_result", cap_res, 32'h87654321);
`else
    chk("lit_lw_unaligned_result", cap_res, 32'hCAFEF00D);
`endif

    // Reset while a read is stalled
    model_on = 0;
    @(negedge clk);
    load = 1; store = 0; load_type = 3'd1; eff_addr = 32'h104; waitrequest = 1; start = 1;
    @(negedge clk);
    start = 0;
    chk("rst_mid_read_before", read, 1);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("rst_mid_read", read, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_result", load_result, 0);
    @(negedge clk);
    reset = 0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_read", read, 0);
    end
    waitrequest = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
